// File: rtl/y_output_writer.sv
// y_output_writer: buffers the intermediator's y stream and issues sequential 64-bit writes to the y vector.
// Optional feature macro Y_IEEE_CONVERT_EN: when defined, FloPoCo values are converted to IEEE-754 double.
module y_output_writer #(
    parameter int FIFO_DEPTH      = 64,
    parameter int LOG2_FIFO_DEPTH = $clog2(FIFO_DEPTH - 1),
    parameter int STALL_MARGIN    = 16,
    parameter int ADDR_WIDTH      = 48,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] y_count,
    input  logic                   push_to_y,
    input  logic [65:0]            v_to_y,
    output logic                   stall_out,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [63:0]            mem_data,
    input  logic                   mem_stall,
    output logic                   done,
    output logic                   overflow_err
);

    localparam int CNT_W = LOG2_FIFO_DEPTH + 1;
    localparam logic [CNT_W-1:0]           DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]           THRESH_C  = CNT_W'(FIFO_DEPTH - STALL_MARGIN);
    localparam logic [CNT_W-1:0]           CNT_ONE_C = CNT_W'(1);
    localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE_C = LOG2_FIFO_DEPTH'(1);
    localparam logic [COUNT_WIDTH-1:0]     ROW_ONE_C = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      base_addr_q, base_addr_d;
    logic [COUNT_WIDTH-1:0]     y_count_q, y_count_d;
    logic [COUNT_WIDTH-1:0]     issued_q, issued_d;
    logic [COUNT_WIDTH-1:0]     loaded_q, loaded_d;
    logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [63:0]                mem_data_q, mem_data_d;
    logic                       done_q, done_d;
    logic                       stall_out_q, stall_out_d;
    logic                       overflow_q, overflow_d;
    logic [65:0]                fifo_mem_q [FIFO_DEPTH];

    logic                       fifo_full_s;
    logic                       accept_s;
    logic                       pop_s;
    logic                       push_ok_s;
    logic [65:0]                fifo_rd_s;
    logic [63:0]                conv_data_s;
    logic [ADDR_WIDTH-1:0]      idx_ext_s;
    logic [ADDR_WIDTH-1:0]      offset_s;

    assign fifo_rd_s = fifo_mem_q[rd_ptr_q];

`ifdef Y_IEEE_CONVERT_EN
    function automatic logic [63:0] flopoco_to_ieee(input logic [65:0] v);
        logic [63:0] r;
        case (v[65:64])
            2'b00:   r = {v[63], 63'd0};
            2'b01:   r = v[63:0];
            2'b10:   r = {v[63], 11'h7FF, 52'd0};
            2'b11:   r = 64'h7FF8_0000_0000_0000;
            default: r = 64'h7FF8_0000_0000_0000;
        endcase
        return r;
    endfunction

    assign conv_data_s = flopoco_to_ieee(fifo_rd_s);
`else
    logic unused_exc_s;
    assign conv_data_s  = fifo_rd_s[63:0];
    assign unused_exc_s = ^fifo_rd_s[65:64];
`endif

    // Writes carry the load index, which equals the accept index since the register drains in order.
    assign idx_ext_s = ADDR_WIDTH'(loaded_q);
    assign offset_s  = idx_ext_s << 2'd3;

    // Handshake terms: accept, pop (bounded by the job length) and push admission.
    always_comb begin
        fifo_full_s = (count_q == DEPTH_C);
        accept_s    = mem_req_q && !mem_stall;
        pop_s       = (count_q != '0) && (state_q == ST_RUN) &&
                      (!mem_req_q || accept_s) && (loaded_q != y_count_q);
        push_ok_s   = push_to_y && (!fifo_full_s || pop_s);
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Job FSM and row counters; done is decided from the post-accept count so it rises one cycle after the last accept.
    always_comb begin
        state_d     = state_q;
        base_addr_d = base_addr_q;
        y_count_d   = y_count_q;
        issued_d    = issued_q;
        loaded_d    = loaded_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    base_addr_d = base_addr;
                    y_count_d   = y_count;
                    issued_d    = '0;
                    loaded_d    = '0;
                    state_d     = (y_count == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                issued_d = accept_s ? (issued_q + ROW_ONE_C) : issued_q;
                loaded_d = pop_s ? (loaded_q + ROW_ONE_C) : loaded_q;
                if (issued_d == y_count_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: loads on a pop, clears on an accept, otherwise holds (stable while stalled).
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (pop_s) begin
            mem_req_d  = 1'b1;
            mem_addr_d = base_addr_q + offset_s;
            mem_data_d = conv_data_s;
        end else if (accept_s) begin
            mem_req_d = 1'b0;
        end else begin
            mem_req_d = mem_req_q;
        end
    end

    // Status flags.
    always_comb begin
        done_d      = (state_d == ST_DONE);
        stall_out_d = (count_q >= THRESH_C) || (state_q != ST_RUN);
        overflow_d  = overflow_q || (push_to_y && fifo_full_s && !pop_s);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem_q[wr_ptr_q] <= v_to_y;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_addr_q <= '0;
            y_count_q   <= '0;
            issued_q    <= '0;
            loaded_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= 64'd0;
            done_q      <= 1'b0;
            stall_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_addr_q <= base_addr_d;
            y_count_q   <= y_count_d;
            issued_q    <= issued_d;
            loaded_q    <= loaded_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            done_q      <= done_d;
            stall_out_q <= stall_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign stall_out    = stall_out_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign done         = done_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_y_output_writer.sv
// Self-checking bench for y_output_writer: table vectors, directed corner sequences and randomized jobs.
module tb_y_output_writer;
    localparam int AW = 48;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, push_to_y = 1'b0, mem_stall = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   y_count = '0;
    logic [65:0]   v_to_y = '0;
    logic          stall_out, mem_req, done, overflow_err;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_data;

    always #5 clk = ~clk;

    y_output_writer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .y_count(y_count),
        .push_to_y(push_to_y), .v_to_y(v_to_y), .stall_out(stall_out), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_stall(mem_stall), .done(done),
        .overflow_err(overflow_err)
    );

    int tests = 0, fails = 0;
    int cyc = 0;
    logic [AW-1:0] cap_addr[$];
    logic [63:0]   cap_data[$];
    int            cap_edge[$];
    logic [63:0]   exp_data[$];
    int req_seen = 0, done_edge = -1, hold_bad = 0, hold_cnt = 0;
    logic done_prev = 1'b0, hold_v = 1'b0;
    logic [AW-1:0] hold_a = '0;
    logic [63:0]   hold_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every accepted write and checks that stalled requests hold still.
    always @(negedge clk) begin
        if (!rst && hold_v) begin
            hold_cnt <= hold_cnt + 1;
            if (mem_req !== 1'b1 || mem_addr !== hold_a || mem_data !== hold_d) hold_bad <= hold_bad + 1;
        end
        hold_v <= !rst && mem_req && mem_stall;
        hold_a <= mem_addr;
        hold_d <= mem_data;
        if (!rst && mem_req && !mem_stall) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_data);
            cap_edge.push_back(cyc + 1);
        end
        if (!rst && mem_req) req_seen <= req_seen + 1;
        if (!rst && done && !done_prev) done_edge <= cyc;
        done_prev <= done && !rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_conv(input logic [65:0] v);
`ifdef Y_IEEE_CONVERT_EN
        if (v[65:64] == 2'b00) return {v[63], 63'd0};
        if (v[65:64] == 2'b01) return v[63:0];
        if (v[65:64] == 2'b10) return {v[63], 11'h7FF, 52'd0};
        return 64'h7FF8_0000_0000_0000;
`else
        return v[63:0];
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; push_to_y = 1'b0; mem_stall = 1'b0;
        tick();
        chk("rst_stall_out", {63'd0, stall_out}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [31:0] n);
        base_addr = b; y_count = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_writes(input int bi, input int n, input int budget);
        int k = 0;
        while (cap_addr.size() - bi < n && k < budget) begin
            tick();
            k++;
        end
        chk("write_count", 64'(cap_addr.size() - bi), 64'(n));
    endtask

    task automatic check_writes(input int bi, input logic [AW-1:0] b, input int n);
        for (int j = 0; j < n && bi + j < cap_addr.size(); j++) begin
            logic [AW-1:0] ea;
            ea = b + AW'(j) * AW'(8);
            chk("addr", 64'(cap_addr[bi + j]), 64'(ea));
            chk("data", cap_data[bi + j], exp_data[j]);
        end
    endtask

    typedef struct {
        logic [65:0] v;
        logic [63:0] ieee;
    } vec_t;

    task automatic run_rand(input logic [AW-1:0] b, input int n);
        int bi, pushed, k;
        logic [65:0] v;
        exp_data.delete();
        bi = cap_addr.size(); pushed = 0; k = 0;
        start_job(b, 32'(n));
        while ((pushed < n || cap_addr.size() - bi < n) && k < 3000) begin
            mem_stall = ($urandom_range(0, 3) == 0);
            if (pushed < n && !stall_out && $urandom_range(0, 2) != 0) begin
                v = {2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)};
                v_to_y = v; push_to_y = 1'b1;
                exp_data.push_back(ref_conv(v));
                pushed++;
            end else begin
                push_to_y = 1'b0;
            end
            tick();
            k++;
        end
        push_to_y = 1'b0; mem_stall = 1'b0;
        chk("rand_write_count", 64'(cap_addr.size() - bi), 64'(n));
        tick();
        chk("rand_done", {63'd0, done}, 64'd1);
        chk("rand_overflow", {63'd0, overflow_err}, 64'd0);
        check_writes(bi, b, n);
        if (cap_edge.size() > 0) chk("rand_done_timing", 64'(done_edge), 64'(cap_edge[cap_edge.size() - 1]));
    endtask

    vec_t tbl[7];

    initial begin
        int bi, rb, gaps;
        logic [65:0] tv;
        tbl[0] = '{{2'b01, 64'h3FF0_0000_0000_0000}, 64'h3FF0_0000_0000_0000};
        tbl[1] = '{{2'b01, 64'h4000_0000_0000_0000}, 64'h4000_0000_0000_0000};
        tbl[2] = '{{2'b01, 64'h4008_0000_0000_0000}, 64'h4008_0000_0000_0000};
        tbl[3] = '{{2'b01, 64'h4010_0000_0000_0000}, 64'h4010_0000_0000_0000};
        tbl[4] = '{{2'b00, 1'b1, 11'h123, 52'h5},    64'h8000_0000_0000_0000};
        tbl[5] = '{{2'b10, 1'b0, 11'h003, 52'hABC},  64'h7FF0_0000_0000_0000};
        tbl[6] = '{{2'b11, 1'b1, 11'h007, 52'h1},    64'h7FF8_0000_0000_0000};

        do_reset();

        // Table vectors: normals and exception codes, streamed back to back.
        exp_data.delete();
        for (int i = 0; i < 7; i++) begin
            tv = tbl[i].v;
`ifdef Y_IEEE_CONVERT_EN
            exp_data.push_back(tbl[i].ieee);
`else
            exp_data.push_back(tv[63:0]);
`endif
        end
        bi = cap_addr.size();
        start_job(48'h1000, 32'd7);
        for (int i = 0; i < 7; i++) begin
            push_to_y = 1'b1; v_to_y = tbl[i].v;
            tick();
            if (i == 0) chk("latency_n1", {63'd0, mem_req}, 64'd0);
            if (i == 1) chk("latency_n2", {63'd0, mem_req}, 64'd1);
        end
        push_to_y = 1'b0;
        wait_writes(bi, 7, 50);
        tick();
        check_writes(bi, 48'h1000, 7);
        chk("basic_done", {63'd0, done}, 64'd1);
        chk("basic_done_timing", 64'(done_edge), 64'(cap_edge[cap_edge.size() - 1]));

        // Zero-length job from DONE.
        rb = req_seen;
        start_job(48'h7000, 32'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        repeat (10) tick();
        chk("zero_no_req", 64'(req_seen - rb), 64'd0);

        // Backpressure: fill while stalled, then release with a push on the full FIFO.
        do_reset();
        exp_data.delete();
        bi = cap_addr.size();
        start_job(48'h3000, 32'd66);
        mem_stall = 1'b1;
        for (int i = 0; i < 65; i++) begin
            tv = {2'b01, 64'h0123_0000_0000_0000 + 64'(i)};
            push_to_y = 1'b1; v_to_y = tv;
            exp_data.push_back(ref_conv(tv));
            tick();
            if (i == 48) chk("stall_out_before", {63'd0, stall_out}, 64'd0);
            if (i == 49) chk("stall_out_rise", {63'd0, stall_out}, 64'd1);
        end
        chk("bp_full_no_ovf", {63'd0, overflow_err}, 64'd0);
        tv = {2'b01, 64'h0123_0000_0000_0000 + 64'd65};
        mem_stall = 1'b0; v_to_y = tv;
        exp_data.push_back(ref_conv(tv));
        tick();
        push_to_y = 1'b0;
        chk("bp_push_pop_full", {63'd0, overflow_err}, 64'd0);
        wait_writes(bi, 66, 200);
        tick();
        check_writes(bi, 48'h3000, 66);
        gaps = 0;
        for (int j = bi + 1; j < cap_edge.size(); j++) if (cap_edge[j] != cap_edge[j - 1] + 1) gaps++;
        chk("bp_no_gaps", 64'(gaps), 64'd0);
        chk("bp_done", {63'd0, done}, 64'd1);

        // Overflow: 65 pushes while IDLE, 65th is dropped.
        do_reset();
        exp_data.delete();
        mem_stall = 1'b1;
        for (int i = 0; i < 65; i++) begin
            tv = {2'b01, 64'h4000_0000_0000_0000 + 64'(i)};
            push_to_y = 1'b1; v_to_y = tv;
            if (i < 64) exp_data.push_back(ref_conv(tv));
            tick();
            if (i == 63) chk("ovf_at_full", {63'd0, overflow_err}, 64'd0);
        end
        push_to_y = 1'b0;
        chk("ovf_set", {63'd0, overflow_err}, 64'd1);
        bi = cap_addr.size();
        start_job(48'h2000, 32'd65);
        mem_stall = 1'b0;
        wait_writes(bi, 64, 200);
        repeat (20) tick();
        chk("ovf_exact_64", 64'(cap_addr.size() - bi), 64'd64);
        chk("ovf_not_done", {63'd0, done}, 64'd0);
        chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
        check_writes(bi, 48'h2000, 64);

        // Reset after three accepted writes, then a fresh job.
        do_reset();
        bi = cap_addr.size();
        start_job(48'h5000, 32'd8);
        for (int i = 0; i < 8; i++) begin
            push_to_y = 1'b1; v_to_y = {2'b01, 64'h5555_0000_0000_0000 + 64'(i)};
            tick();
            if (cap_addr.size() - bi >= 3) break;
        end
        push_to_y = 1'b0;
        chk("mid_accepts", 64'(cap_addr.size() - bi), 64'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {63'd0, mem_req}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_stall", {63'd0, stall_out}, 64'd0);
        chk("mid_rst_ovf", {63'd0, overflow_err}, 64'd0);
        rst = 1'b0;
        tick();
        exp_data.delete();
        bi = cap_addr.size();
        start_job(48'h9000, 32'd2);
        for (int i = 0; i < 2; i++) begin
            tv = {2'b01, 64'h6666_0000_0000_0000 + 64'(i)};
            push_to_y = 1'b1; v_to_y = tv;
            exp_data.push_back(ref_conv(tv));
            tick();
        end
        push_to_y = 1'b0;
        wait_writes(bi, 2, 50);
        repeat (10) tick();
        chk("mid_new_count", 64'(cap_addr.size() - bi), 64'd2);
        chk("mid_new_done", {63'd0, done}, 64'd1);
        check_writes(bi, 48'h9000, 2);

        // Randomized jobs, including an address wrap.
        run_rand(48'hFFFF_FFFF_FFE0, 12);
        for (int r = 0; r < 5; r++) begin
            logic [AW-1:0] b;
            b = {16'($urandom), 32'($urandom)};
            b[2:0] = 3'b000;
            run_rand(b, $urandom_range(1, 40));
        end

        chk("hold_stable", 64'(hold_bad), 64'd0);
        chk("hold_exercised", 64'(hold_cnt > 0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
